// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared types and seven-segment table for the oven countdown timer
// Contents: state_t controller states, SEG_TABLE digit patterns (active-low),
//           SEG_BLANK pattern, seg_decode helper.
package oven_pkg;

    typedef enum logic [1:0] {
        ST_SET    = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (digit < 4'd10) begin
            seg = SEG_TABLE[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchroniser, debouncer and press/auto-repeat pulse generator
// Ports: clk, rst (sync, active-high), btn_n (raw active-low button),
//        pulse (one cycle per accepted press, plus auto-repeat when REPEAT_EN).
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pulse
);
    import oven_pkg::*;

    localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RPW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_CYC - 1);

    logic           sync1;
    logic           sync2;
    logic           level;
    logic [DBW-1:0] db_cnt;
    logic [RPW-1:0] rep_cnt;
    logic           accept;
    logic           accept_press;

    // db_cnt counts consecutive synced samples that differ from the accepted
    // level; the last of DEBOUNCE_CYC such samples flips the level.
    assign accept       = (sync2 != level) && (db_cnt == DB_LAST);
    assign accept_press = accept && !sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            db_cnt  <= '0;
            rep_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            pulse <= 1'b0;

            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (accept) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end

            // Repeat phase is anchored to the accepted press edge.
            if (accept_press) begin
                pulse   <= 1'b1;
                rep_cnt <= '0;
            end else if (REPEAT_EN && !level) begin
                if (rep_cnt == RP_LAST) begin
                    pulse   <= 1'b1;
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + RPW'(1);
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/oven_countdown_timer.sv
// rtl/oven_countdown_timer.sv - oven countdown timer: preset entry, run/pause, done, 4-digit display
// Ports: clk, rst (sync, active-high); btn_up_n/btn_dn_n/btn_start_n/btn_stop_n raw
//        active-low buttons; hex0..hex3 active-low segments (sec ones, sec tens,
//        min ones, min tens); running, done status; remaining seconds (binary).
module oven_countdown_timer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int REPEAT_CYC   = 10_000_000,
    parameter int STEP_SEC     = 5,
    parameter int MAX_SEC      = 5999
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_up_n,
    input  logic                           btn_dn_n,
    input  logic                           btn_start_n,
    input  logic                           btn_stop_n,
    output logic [6:0]                     hex0,
    output logic [6:0]                     hex1,
    output logic [6:0]                     hex2,
    output logic [6:0]                     hex3,
    output logic                           running,
    output logic                           done,
    output logic [$clog2(MAX_SEC+1)-1:0]   remaining
);
    import oven_pkg::*;

    localparam int RW = $clog2(MAX_SEC + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic          up_p, dn_p, start_p, stop_p;
    state_t        state, state_d;
    logic [RW-1:0] preset, preset_d;
    logic [PW-1:0] presc;
    logic          tick_due;
    logic          enter_run;
    logic [RW-1:0] disp_val, mins, secs;

    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
        u_up    (.clk(clk), .rst(rst), .btn_n(btn_up_n),    .pulse(up_p));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
        u_dn    (.clk(clk), .rst(rst), .btn_n(btn_dn_n),    .pulse(dn_p));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
        u_start (.clk(clk), .rst(rst), .btn_n(btn_start_n), .pulse(start_p));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
        u_stop  (.clk(clk), .rst(rst), .btn_n(btn_stop_n),  .pulse(stop_p));

    assign tick_due = (presc == PW'(TICK_DIV - 1));

    // Stop always wins over start when both pulse together.
    always_comb begin
        state_d   = state;
        enter_run = 1'b0;
        case (state)
            ST_SET: begin
                if (start_p && !stop_p && preset != '0) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_p) begin
                    state_d = ST_PAUSED;
                end else if (tick_due && remaining == RW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSED: begin
                if (stop_p) begin
                    state_d = ST_SET;
                end else if (start_p) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_DONE: begin
                if (up_p || dn_p || start_p || stop_p) begin
                    state_d = ST_SET;
                end
            end
            default: state_d = ST_SET;
        endcase
    end

    always_comb begin
        preset_d = preset;
        if (state == ST_SET && up_p && !dn_p) begin
            preset_d = (int'(preset) > MAX_SEC - STEP_SEC) ? RW'(MAX_SEC) : preset + RW'(STEP_SEC);
        end else if (state == ST_SET && dn_p && !up_p) begin
            preset_d = (int'(preset) < STEP_SEC) ? '0 : preset - RW'(STEP_SEC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SET;
            preset    <= '0;
            remaining <= '0;
            presc     <= '0;
        end else begin
            state  <= state_d;
            preset <= preset_d;
            if (enter_run) begin
                // Resume from PAUSED keeps remaining but restarts the second.
                presc <= '0;
                if (state == ST_SET) begin
                    remaining <= preset;
                end
            end else if (state == ST_RUN && !stop_p) begin
                if (tick_due) begin
                    presc     <= '0;
                    remaining <= remaining - RW'(1);
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    always_comb begin
        disp_val = (state == ST_SET) ? preset : remaining;
        mins     = disp_val / RW'(60);
        secs     = disp_val % RW'(60);
        hex0     = seg_decode(4'(secs % RW'(10)));
        hex1     = seg_decode(4'(secs / RW'(10)));
        hex2     = seg_decode(4'(mins % RW'(10)));
        hex3     = seg_decode(4'(mins / RW'(10)));
    end

endmodule

// File: tb/tb_oven_countdown_timer.sv
// tb/tb_oven_countdown_timer.sv - self-checking bench for oven_countdown_timer
module tb_oven_countdown_timer;

    localparam int TICK = 10;
    localparam int DEB  = 4;
    localparam int REP  = 20;
    localparam int STEP = 5;
    localparam int MAXS = 5999;
    localparam int RW   = 13;

    localparam int M_SET = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    btn_n = 4'hF;   // 0 up, 1 down, 2 start, 3 stop
    logic [6:0]    hex0, hex1, hex2, hex3;
    logic          running, done;
    logic [RW-1:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    oven_countdown_timer #(
        .TICK_DIV(TICK), .DEBOUNCE_CYC(DEB), .REPEAT_CYC(REP), .STEP_SEC(STEP), .MAX_SEC(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up_n(btn_n[0]), .btn_dn_n(btn_n[1]), .btn_start_n(btn_n[2]), .btn_stop_n(btn_n[3]),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .running(running), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int      m_state, m_preset, m_rem;
    longint  cyc, next_tick;
    bit      hist [4][8];    // raw samples, index 0 = sampled at this edge
    bit      lvl  [4];
    longint  rep_base [4];
    bit      pend [4];       // press pulses the controller sees at the next edge

    always @(posedge clk) begin : model_blk
        bit acc;
        bit gen [4];
        int disp, mm, ss;
        cyc++;
        if (rst) begin
            m_state = M_SET; m_preset = 0; m_rem = 0;
            for (int b = 0; b < 4; b++) begin
                for (int j = 0; j < 8; j++) hist[b][j] = 1'b1;
                lvl[b] = 1'b1; pend[b] = 1'b0; rep_base[b] = 0;
            end
        end else begin
            case (m_state)
                M_SET: begin
                    if (pend[2] && !pend[3] && m_preset != 0) begin
                        m_state = M_RUN; m_rem = m_preset; next_tick = cyc + TICK;
                    end
                    if (pend[0] && !pend[1]) m_preset = (m_preset + STEP > MAXS) ? MAXS : m_preset + STEP;
                    else if (pend[1] && !pend[0]) m_preset = (m_preset < STEP) ? 0 : m_preset - STEP;
                end
                M_RUN: begin
                    if (pend[3]) m_state = M_PAUSED;
                    else if (cyc == next_tick) begin
                        m_rem--; next_tick = cyc + TICK;
                        if (m_rem == 0) m_state = M_DONE;
                    end
                end
                M_PAUSED: begin
                    if (pend[3]) m_state = M_SET;
                    else if (pend[2]) begin m_state = M_RUN; next_tick = cyc + TICK; end
                end
                default: if (pend[0] || pend[1] || pend[2] || pend[3]) m_state = M_SET;
            endcase
            for (int b = 0; b < 4; b++) begin
                for (int j = 7; j > 0; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = btn_n[b];
                // a new level is accepted once DEB consecutive synchronised samples disagree with it
                acc = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) if (hist[b][j] == lvl[b]) acc = 1'b0;
                gen[b] = 1'b0;
                if (acc && lvl[b]) begin
                    gen[b] = 1'b1; rep_base[b] = cyc;
                end else if (b < 2 && !lvl[b] && cyc > rep_base[b] && (cyc - rep_base[b]) % REP == 0) begin
                    gen[b] = 1'b1;
                end
                if (acc) lvl[b] = !lvl[b];
            end
            for (int b = 0; b < 4; b++) pend[b] = gen[b];
        end
        #1;
        disp = (m_state == M_SET) ? m_preset : m_rem;
        mm = disp / 60; ss = disp % 60;
        check("running",   32'(running),   32'(m_state == M_RUN));
        check("done",      32'(done),      32'(m_state == M_DONE));
        check("remaining", 32'(remaining), 32'(m_rem));
        check("hex0", 32'(hex0), 32'(SEG[ss % 10]));
        check("hex1", 32'(hex1), 32'(SEG[ss / 10]));
        check("hex2", 32'(hex2), 32'(SEG[mm % 10]));
        check("hex3", 32'(hex3), 32'(SEG[mm / 10]));
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        @(negedge clk);
        btn_n[b] = 1'b0;
        wait_n(hold);
        btn_n[b] = 1'b1;
        wait_n(10);
    endtask

    task automatic wait_running(input string nm);
        for (int i = 0; i < 40 && !running; i++) @(negedge clk);
        check(nm, 32'(running), 32'd1);
    endtask

    task automatic check_disp(input string nm, input logic [6:0] h3, input logic [6:0] h2,
                              input logic [6:0] h1, input logic [6:0] h0);
        check({nm, "_hex3"}, 32'(hex3), 32'(h3));
        check({nm, "_hex2"}, 32'(hex2), 32'(h2));
        check({nm, "_hex1"}, 32'(hex1), 32'(h1));
        check({nm, "_hex0"}, 32'(hex0), 32'(h0));
    endtask

    int dur [4];
    int t;

    initial begin
        wait_n(3);
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check_disp("rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
        rst = 1'b0;
        wait_n(2);

        // three up taps -> 00:15
        repeat (3) press(0, 8);
        check_disp("preset15", 7'b1000000, 7'b1000000, 7'b1111001, 7'b0010010);
        check("preset15_running", 32'(running), 32'd0);

        // down to 10, run to completion
        press(1, 8);
        @(negedge clk); btn_n[2] = 1'b0;
        wait_running("run10_start");
        btn_n[2] = 1'b1;
        wait_n(9);
        check("run10_before_tick", 32'(remaining), 32'd10);
        wait_n(1);
        check("run10_first_tick", 32'(remaining), 32'd9);
        t = 10;
        while (t < 200 && !done) begin @(negedge clk); t++; end
        check("run10_cycles_to_done", 32'(t), 32'd100);
        check("run10_done", 32'(done), 32'd1);
        check("run10_remaining", 32'(remaining), 32'd0);
        check_disp("run10_end", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

        // done -> set, preset kept
        press(3, 8);
        check_disp("after_done", 7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000);

        // pause at 7, hold, resume, stop twice
        @(negedge clk); btn_n[2] = 1'b0;
        wait_running("pause_run_start");
        btn_n[2] = 1'b1;
        wait_n(25);
        btn_n[3] = 1'b0;
        wait_n(10);
        btn_n[3] = 1'b1;
        check("paused_running", 32'(running), 32'd0);
        check("paused_remaining", 32'(remaining), 32'd7);
        wait_n(50);
        check("paused_hold", 32'(remaining), 32'd7);
        btn_n[2] = 1'b0;
        wait_running("resume_start");
        btn_n[2] = 1'b1;
        wait_n(9);
        check("resume_before_tick", 32'(remaining), 32'd7);
        wait_n(1);
        check("resume_first_tick", 32'(remaining), 32'd6);
        press(3, 8);
        press(3, 8);
        check("stop2_running", 32'(running), 32'd0);
        check_disp("stop2_preset", 7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000);

        // up and down together are ignored
        @(negedge clk); btn_n[1:0] = 2'b00;
        wait_n(30);
        btn_n[1:0] = 2'b11;
        wait_n(10);
        check_disp("updown", 7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000);

        // bouncing start produces no press
        repeat (4) begin
            @(negedge clk); btn_n[2] = 1'b0;
            wait_n(2); btn_n[2] = 1'b1;
            wait_n(1);
        end
        wait_n(10);
        check("glitch_running", 32'(running), 32'd0);

        // start and stop together in RUN pause the timer
        @(negedge clk); btn_n[2] = 1'b0;
        wait_running("ss_run_start");
        btn_n[2] = 1'b1;
        wait_n(8);
        btn_n[3:2] = 2'b00;
        wait_n(10);
        btn_n[3:2] = 2'b11;
        wait_n(8);
        check("ss_running", 32'(running), 32'd0);
        check("ss_done", 32'(done), 32'd0);
        press(3, 8);

        // reset mid-run
        @(negedge clk); btn_n[2] = 1'b0;
        wait_running("rst_run_start");
        btn_n[2] = 1'b1;
        wait_n(15);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_remaining", 32'(remaining), 32'd0);
        check_disp("midrst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

        // down at zero stays zero
        press(1, 8);
        check_disp("down_at_zero", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

        // hold up long enough to hit the ceiling 99:59
        @(negedge clk); btn_n[0] = 1'b0;
        wait_n(24200);
        check_disp("saturate", 7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000);
        btn_n[0] = 1'b1;
        wait_n(10);

        // randomised activity, checked cycle by cycle by the model
        for (int b = 0; b < 4; b++) dur[b] = 0;
        rst = 1'b1; wait_n(2); rst = 1'b0;
        repeat (9000) begin
            @(negedge clk);
            rst = ($urandom_range(2999) == 0);
            for (int b = 0; b < 4; b++) begin
                if (dur[b] == 0) begin
                    if (btn_n[b]) begin
                        btn_n[b] = 1'b0;
                        dur[b] = $urandom_range(1, 30);
                    end else begin
                        btn_n[b] = 1'b1;
                        dur[b] = (b < 2) ? $urandom_range(5, 60) : $urandom_range(20, 200);
                    end
                end else begin
                    dur[b]--;
                end
            end
        end
        rst = 1'b0;
        btn_n = 4'hF;
        wait_n(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oven_countdown_timer.md
OVEN_COUNTDOWN_TIMER -- requirements
Module: oven_countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: clk cycles per one-second tick.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 500_000: cycles a raw button level must stay stable before it is accepted.
REQ-003 SHALL have parameter REPEAT_CYC, default 10_000_000: auto-repeat period while up/down is held.
REQ-004 SHALL have parameter STEP_SEC, default 5: seconds added or removed per up/down event.
REQ-005 SHALL have parameter MAX_SEC, default 5999 (99:59); remaining-time width SHALL be $clog2(MAX_SEC+1).
REQ-006 SHALL have port clk, input, 1 bit: sole clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have ports btn_up_n, btn_dn_n, btn_start_n, btn_stop_n, each input, 1 bit: raw asynchronous buttons, active-low.
REQ-009 SHALL have ports hex0..hex3, each output, 7 bits: active-low segment patterns for sec ones, sec tens, min ones, min tens.
REQ-010 SHALL have port running, output, 1 bit: high in RUN.
REQ-011 SHALL have port done, output, 1 bit: high in DONE.
REQ-012 SHALL have port remaining, output, width per REQ-005: remaining seconds, binary.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser, then a debouncer that accepts a new level after DEBOUNCE_CYC consecutive equal samples.
REQ-014 SHALL emit a one-cycle press pulse on each accepted high-to-low transition; up/down SHALL also pulse every REPEAT_CYC cycles while held; start/stop SHALL NOT repeat.
REQ-015 SHALL implement states SET, RUN, PAUSED, DONE.
REQ-016 In SET, an up pulse SHALL add STEP_SEC to preset, saturating at MAX_SEC; a down pulse SHALL subtract STEP_SEC, saturating at 0. Up and down pulsing in the same cycle SHALL be ignored.
REQ-017 SET to RUN SHALL occur on start when preset is non-zero; remaining SHALL load preset on the same edge; start with preset 0 SHALL be ignored.
REQ-018 Entering RUN from any state SHALL clear the tick prescaler; the first decrement SHALL occur exactly TICK_DIV cycles later.
REQ-019 In RUN, each tick SHALL decrement remaining by 1; the tick that reaches 0 SHALL move to DONE on the same edge.
REQ-020 In RUN, stop SHALL move to PAUSED; remaining and prescaler SHALL freeze.
REQ-021 In PAUSED, start SHALL resume RUN per REQ-018; stop SHALL return to SET with preset unchanged.
REQ-022 In DONE, any press pulse SHALL return to SET with preset unchanged.
REQ-023 Start and stop pulsing in the same cycle SHALL be treated as stop only.
REQ-024 Up/down SHALL be ignored outside SET.
REQ-025 Displayed value SHALL be preset in SET, remaining otherwise, split as minutes = v/60 and seconds = v%60, each into tens/ones digits; decode SHALL be combinational from registers (0-cycle latency after the register update).
REQ-026 Digit 0..9 SHALL map to 7'b1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; any other value SHALL drive 7'b1111111.

Reset
REQ-027 On rst, state SHALL be SET; preset, remaining, prescaler, debounce and repeat counters SHALL be 0; debounced levels SHALL be 1 (released).
REQ-028 After reset: running=0, done=0, remaining=0, hex0..hex3=7'b1000000.
REQ-029 rst asserted in any state, including mid-RUN, SHALL take effect on the next edge and override all other inputs.

Structure
REQ-030 A shared package oven_pkg SHALL hold the state enum, the digit-to-segment table and the blank constant.
REQ-031 Button conditioning SHALL be the sub-module button_conditioner (params DEBOUNCE_CYC, REPEAT_CYC, REPEAT_EN), instantiated four times.

Verification (TICK_DIV=10, DEBOUNCE_CYC=4, REPEAT_CYC=20, STEP_SEC=5, MAX_SEC=5999)
REQ-032 Reset, then tap up 3 times -> preset=15; hex3..hex0 show 0,0,1,5; running=0.
REQ-033 Preset 10, start -> running=1 on the edge of the start pulse; remaining=9 exactly 10 cycles later; after 100 cycles: done=1, remaining=0, display 0000.
REQ-034 Preset 5995, hold up for 60 cycles -> preset saturates at 5999 (99:59); down at preset 0 -> stays 0; up+down in the same cycle -> no change.
REQ-035 RUN with remaining=7, stop, wait 50 cycles -> remaining=7; start -> 6 after 10 cycles; stop twice -> SET, preset unchanged.
REQ-036 Raw button bounce of 2-cycle glitches -> no pulse; start+stop pulsing in the same cycle during RUN -> PAUSED.
REQ-037 rst asserted mid-RUN -> next edge: SET, remaining=0, running=0, done=0.
